// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder: oversampled sck/cs/sdi, byte-wide receive strobe, one-deep transmit holding register.
// Build option: define SPI_SLAVE_LOOPBACK_EN to echo the last received word instead of DEFAULT_TX on underrun.
module spi_slave_responder #(
    parameter int                 DATA_W     = 8,
    parameter logic [DATA_W-1:0]  DEFAULT_TX = DATA_W'(8'hFF)
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs,
    input  logic              sdi,
    output logic              sdo,
    input  logic [DATA_W-1:0] tx_dat,
    input  logic              tx_flag,
    output logic              tx_empty,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_dat,
    output logic              rx_flag,
    output logic              busy
);

    localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state;
    logic               sck_s1, sck_s2, sck_prev;
    logic               cs_s1, cs_s2, cs_prev;
    logic               sdi_s1, sdi_s2;
    logic [1:0]         sync_fill;
    logic               cs_armed;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  tx_shift;
    logic [DATA_W-2:0]  rx_shift;
    logic [DATA_W-1:0]  hold_dat;

    logic               sck_rise, sck_fall, cs_fall, cs_rise;
    logic               word_load;
    logic [DATA_W-1:0]  load_word;
    logic [DATA_W-1:0]  rx_next;

    // cs_armed blocks a start until cs has really been observed high after reset,
    // so a reset taken with cs held low cannot fake a falling edge.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            sck_s1    <= 1'b0;
            sck_s2    <= 1'b0;
            sck_prev  <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_prev   <= 1'b1;
            sdi_s1    <= 1'b0;
            sdi_s2    <= 1'b0;
            sync_fill <= 2'b00;
            cs_armed  <= 1'b0;
        end else begin
            sck_s1    <= sck;
            sck_s2    <= sck_s1;
            sck_prev  <= sck_s2;
            cs_s1     <= cs;
            cs_s2     <= cs_s1;
            cs_prev   <= cs_s2;
            sdi_s1    <= sdi;
            sdi_s2    <= sdi_s1;
            sync_fill <= {sync_fill[0], 1'b1};
            cs_armed  <= cs_armed | (sync_fill[1] & cs_s2);
        end
    end

    assign sck_rise = sck_s2 & ~sck_prev;
    assign sck_fall = ~sck_s2 & sck_prev;
    assign cs_fall  = cs_armed & cs_prev & ~cs_s2;
    assign cs_rise  = cs_s2 & ~cs_prev;
    assign rx_next  = {rx_shift, sdi_s2};

    assign word_load = ((state == IDLE) && cs_fall) ||
                       ((state == ACTIVE) && !cs_rise && sck_fall && (bit_cnt == '0));

    // Word source priority: holding register, then same-cycle bypass, then fallback.
    always_comb begin
        load_word = DEFAULT_TX;
        if (!tx_empty)
            load_word = hold_dat;
        else if (tx_flag)
            load_word = tx_dat;
        else begin
`ifdef SPI_SLAVE_LOOPBACK_EN
            load_word = rx_dat;
`else
            load_word = DEFAULT_TX;
`endif
        end
    end

    assign sdo = (state == ACTIVE) ? tx_shift[DATA_W-1] : 1'b1;

    // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            hold_dat    <= '0;
            tx_empty    <= 1'b1;
            tx_underrun <= 1'b0;
            rx_dat      <= '0;
            rx_flag     <= 1'b0;
        end else begin
            rx_flag     <= 1'b0;
            tx_underrun <= 1'b0;

            if (word_load && !tx_empty) begin
                tx_empty <= 1'b1;
            end else if (tx_flag && tx_empty && !word_load) begin
                hold_dat <= tx_dat;
                tx_empty <= 1'b0;
            end
            if (word_load)
                tx_underrun <= tx_empty & ~tx_flag;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        tx_shift <= load_word;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end else if (sck_rise) begin
                        rx_shift <= rx_next[DATA_W-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            rx_dat  <= rx_next;
                            rx_flag <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt == '0)
                            tx_shift <= load_word;
                        else
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Randomized SPI-master bench for spi_slave_responder; a transaction-level model predicts every word exchanged.
// Honours SPI_SLAVE_LOOPBACK_EN when predicting the underrun fallback word.
module tb_spi_slave_responder;

    localparam logic [7:0] DEF_TX = 8'hFF;
    localparam int         HALF   = 8;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b0;
    logic       sck     = 1'b0;
    logic       cs      = 1'b1;
    logic       sdi     = 1'b0;
    logic       sdo;
    logic [7:0] tx_dat  = 8'h00;
    logic       tx_flag = 1'b0;
    logic       tx_empty, tx_underrun, rx_flag, busy;
    logic [7:0] rx_dat;

    always #5 sys_clk = ~sys_clk;

    spi_slave_responder #(.DATA_W(8), .DEFAULT_TX(DEF_TX)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .sck        (sck),
        .cs         (cs),
        .sdi        (sdi),
        .sdo        (sdo),
        .tx_dat     (tx_dat),
        .tx_flag    (tx_flag),
        .tx_empty   (tx_empty),
        .tx_underrun(tx_underrun),
        .rx_dat     (rx_dat),
        .rx_flag    (rx_flag),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every high cycle of a strobe is recorded, so a stretched pulse shows up as an extra entry.
    logic [7:0] rx_q[$];
    int         ur_seen = 0;
    always @(negedge sys_clk) begin
        if (rx_flag) rx_q.push_back(rx_dat);
        if (tx_underrun) ur_seen++;
    end

    // Transaction-level reference: holding slot, current outgoing word, last received word.
    logic       m_empty;
    logic [7:0] m_hold, m_cur, m_last_rx;
    int         m_ur = 0;

    task automatic model_reset();
        m_empty   = 1'b1;
        m_hold    = 8'h00;
        m_cur     = 8'h00;
        m_last_rx = 8'h00;
    endtask

    task automatic model_write(input logic [7:0] b);
        if (m_empty) begin
            m_hold  = b;
            m_empty = 1'b0;
        end
    endtask

    task automatic model_load(input logic byp, input logic [7:0] bd);
        if (!m_empty) begin
            m_cur   = m_hold;
            m_empty = 1'b1;
        end else if (byp) begin
            m_cur = bd;
        end else begin
`ifdef SPI_SLAVE_LOOPBACK_EN
            m_cur = m_last_rx;
`else
            m_cur = DEF_TX;
`endif
            m_ur++;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic write_tx(input logic [7:0] b);
        tx_dat  = b;
        tx_flag = 1'b1;
        wait_clk(1);
        tx_flag = 1'b0;
        model_write(b);
    endtask

    // tx_flag is raised in the cycle the synchronized cs fall is acted on (third edge after the pin).
    task automatic cs_low(input logic byp, input logic [7:0] bd);
        cs = 1'b0;
        wait_clk(2);
        if (byp) begin
            tx_dat  = bd;
            tx_flag = 1'b1;
        end
        wait_clk(1);
        tx_flag = 1'b0;
        wait_clk(5);
        model_load(byp, bd);
        check("busy_on", busy, 1);
        check("tx_empty_cs", tx_empty, m_empty);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        wait_clk(HALF);
        check("busy_off", busy, 0);
        check("sdo_idle", sdo, 1);
        check("underruns", ur_seen, m_ur);
    endtask

    task automatic spi_word(input logic [7:0] mosi, input logic wr, input logic [7:0] wd);
        logic [7:0] miso;
        miso = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            sdi = mosi[i];
            wait_clk(HALF);
            miso[i] = sdo;
            sck = 1'b1;
            if (i == 0 && wr) begin
                wait_clk(4);
                write_tx(wd);
                wait_clk(HALF - 5);
            end else begin
                wait_clk(HALF);
            end
            sck = 1'b0;
        end
        wait_clk(HALF);
        check("miso", miso, m_cur);
        check("rx_pulses", rx_q.size(), 1);
        if (rx_q.size() > 0) check("rx_dat_strobe", rx_q.pop_front(), mosi);
        rx_q.delete();
        check("rx_dat_hold", rx_dat, mosi);
        m_last_rx = mosi;
        model_load(1'b0, 8'h00);
    endtask

    task automatic spi_partial(input int n);
        for (int i = 0; i < n; i++) begin
            sdi = 1'($urandom_range(1));
            wait_clk(HALF);
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
        wait_clk(HALF);
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(4);
        check("rst_sdo", sdo, 1);
        check("rst_tx_empty", tx_empty, 1);
        check("rst_underrun", tx_underrun, 0);
        check("rst_rx_dat", rx_dat, 0);
        check("rst_rx_flag", rx_flag, 0);
        check("rst_busy", busy, 0);

        // Preloaded word goes out while 0x91 comes in.
        write_tx(8'hA5);
        check("tx_full", tx_empty, 0);
        cs_low(1'b0, 8'h00);
        spi_word(8'h91, 1'b0, 8'h00);
        cs_high();

        // Nothing preloaded: fallback word and an underrun at the cs fall.
        cs_low(1'b0, 8'h00);
        spi_word(8'h00, 1'b0, 8'h00);
        cs_high();

        // Two words in one frame, second word refilled mid-frame.
        cs_low(1'b0, 8'h00);
        spi_word(8'h3C, 1'b1, 8'h12);
        spi_word(8'hC3, 1'b0, 8'h00);
        cs_high();

        // Aborted partial word, then a clean transfer.
        cs_low(1'b0, 8'h00);
        spi_partial(4);
        cs_high();
        check("partial_no_rx", rx_q.size(), 0);
        cs_low(1'b0, 8'h00);
        spi_word(8'h5A, 1'b0, 8'h00);
        cs_high();

        // Reset mid-word with cs still low must not restart the frame.
        cs_low(1'b0, 8'h00);
        spi_partial(3);
        rst = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(4);
        model_reset();
        spi_partial(8);
        check("rst_mid_no_rx", rx_q.size(), 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_sdo", sdo, 1);
        check("rst_mid_rx_dat", rx_dat, 0);
        cs_high();
        cs_low(1'b0, 8'h00);
        spi_word(8'h77, 1'b0, 8'h00);
        cs_high();

        // Second write into a full holding register is dropped.
        write_tx(8'h11);
        write_tx(8'h22);
        check("tx_full_keep", tx_empty, 0);
        cs_low(1'b0, 8'h00);
        spi_word(8'($urandom), 1'b0, 8'h00);
        cs_high();

        // Write coinciding with the cs fall is bypassed straight into the shifter.
        cs_low(1'b1, 8'h6B);
        spi_word(8'($urandom), 1'b0, 8'h00);
        cs_high();

        for (int t = 0; t < 12; t++) begin
            int nw;
            if ($urandom_range(1) == 1) write_tx(8'($urandom));
            cs_low($urandom_range(3) == 0, 8'($urandom));
            nw = int'($urandom_range(3, 1));
            for (int k = 0; k < nw; k++)
                spi_word(8'($urandom), 1'($urandom_range(1)), 8'($urandom));
            cs_high();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
